// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned HdrW = 16;

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StFlush,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    // Environment side: drives the byte stream, observes memory writes.
    modport master (
        output s_valid, s_data,
        input  s_ready, im_we, im_addr, im_wdata
    );

    // Loader side.
    modport slave (
        input  s_valid, s_data,
        output s_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four bytes, first byte most significant, into a 32-bit word.
module imem_loader_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] sh_q;
    logic [1:0]  idx_q;

    // The completed word includes the byte arriving this cycle.
    assign word       = {sh_q, in_data};
    assign word_valid = in_valid && (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else if (in_valid) begin
            sh_q  <= {sh_q[15:0], in_data};
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: header word count, then big-endian words written to
// consecutive instruction-memory addresses; releases the CPU when complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_loader_if.slave    bus,
    input  logic            load_req,
    output logic            cpu_run,
    output logic            busy,
    output logic            err,
    output logic [ADDR_W:0] words_loaded
);

    localparam logic [31:0]       Capacity = (32'd1 << ADDR_W) - 32'(BASE_ADDR);
    localparam logic [ADDR_W:0]   OneWord  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q;
    logic [HdrW-1:0]   cnt_q;
    logic [ADDR_W:0]   words_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_addr_q;
    logic [31:0]       im_wdata_q;
    logic              cpu_run_q;
    logic              err_q;

    logic              s_ready;
    logic              fire;
    logic              word_valid;
    logic [31:0]       word;
    logic [HdrW-1:0]   hdr_n;
    logic              last_word;

    assign s_ready = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                     (state_q == StData)  || (state_q == StErr);
    assign busy    = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                     (state_q == StData)  || (state_q == StFlush);
    assign fire    = bus.s_valid && s_ready;

    assign hdr_n     = {cnt_q[15:8], bus.s_data};
    assign last_word = (32'(words_q) + 32'd1) == 32'(cnt_q);

    assign bus.s_ready  = s_ready;
    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign err          = err_q;
    assign words_loaded = words_q;

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state_q != StData),
        .in_valid   (fire && (state_q == StData)),
        .in_data    (bus.s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StHdrHi;
            cnt_q      <= '0;
            words_q    <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_run_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            unique case (state_q)
                StHdrHi: begin
                    if (fire) begin
                        cnt_q[15:8] <= bus.s_data;
                        state_q     <= StHdrLo;
                    end
                end
                StHdrLo: begin
                    if (fire) begin
                        cnt_q <= hdr_n;
                        if (hdr_n == '0) begin
                            state_q   <= StDone;
                            cpu_run_q <= 1'b1;
                        end else if (32'(hdr_n) > Capacity) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (word_valid) begin
                        im_we_q    <= 1'b1;
                        im_addr_q  <= ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
                        im_wdata_q <= word;
                        words_q    <= words_q + OneWord;
                        if (last_word) state_q <= StFlush;
                    end
                end
                StFlush: begin
                    state_q   <= StDone;
                    cpu_run_q <= 1'b1;
                end
                StDone: begin
                    if (load_req) begin
                        state_q   <= StHdrHi;
                        cpu_run_q <= 1'b0;
                        words_q   <= '0;
                        cnt_q     <= '0;
                    end
                end
                StErr: begin
                    // Bytes are swallowed here so the upstream source never stalls.
                    if (load_req) begin
                        state_q <= StHdrHi;
                        err_q   <= 1'b0;
                        words_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= StHdrHi;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time.
module tb_imem_loader;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_req = 1'b0;
    logic          cpu_run;
    logic          busy;
    logic          err;
    logic [AW:0]   words_loaded;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .load_req     (load_req),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every memory write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.im_we) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("im_addr", 32'(bus.im_addr), 32'(e.addr));
                check_eq("im_wdata", bus.im_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap = 1'b0, input bit req = 1'b0);
        int   t = 0;
        logic rdy;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        do begin
            rdy = bus.s_ready;
            @(posedge clk); #1;
            t++;
        end while (!rdy && t < 50);
        if (!rdy) check_eq("s_ready_timeout", 32'd0, 32'd1);
        bus.s_valid = 1'b0;
        if (gap) begin
            load_req = req;
            @(posedge clk); #1;
            load_req = 1'b0;
        end
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w,
                             input bit gap = 1'b0, input bit push = 1'b1);
        wr_t e;
        e.addr = addr;
        e.data = w;
        if (push) exp_q.push_back(e);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap, gap);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic wait_run();
        int t = 0;
        while (!cpu_run && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("cpu_run_wait", 32'(cpu_run), 32'd1);
    endtask

    task automatic check_reset_state();
        check_eq("rst_im_we", 32'(bus.im_we), 32'd0);
        check_eq("rst_im_addr", 32'(bus.im_addr), 32'd0);
        check_eq("rst_im_wdata", bus.im_wdata, 32'd0);
        check_eq("rst_cpu_run", 32'(cpu_run), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_words", 32'(words_loaded), 32'd0);
        check_eq("rst_s_ready", 32'(bus.s_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state();

        // Single word; cpu_run must trail the write pulse by one cycle.
        send_hdr(16'h0001);
        send_word(8'd0, 32'h2008_0005);
        check_eq("t1_we_now", 32'(bus.im_we), 32'd1);
        check_eq("t1_run_not_yet", 32'(cpu_run), 32'd0);
        check_eq("t1_flush_ready", 32'(bus.s_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("t1_run", 32'(cpu_run), 32'd1);
        check_eq("t1_we_low", 32'(bus.im_we), 32'd0);
        check_eq("t1_words", 32'(words_loaded), 32'd1);
        check_eq("t1_busy", 32'(busy), 32'd0);

        // Reload with stalls; load_req during loading must be ignored.
        pulse_load_req();
        check_eq("t2_run_clr", 32'(cpu_run), 32'd0);
        check_eq("t2_ready", 32'(bus.s_ready), 32'd1);
        check_eq("t2_words_clr", 32'(words_loaded), 32'd0);
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'h03, 1'b1, 1'b1);
        send_word(8'd0, 32'hDEAD_BEEF, 1'b1);
        send_word(8'd1, 32'h0123_4567, 1'b1);
        send_word(8'd2, 32'h89AB_CDEF, 1'b1);
        wait_run();
        check_eq("t2_words", 32'(words_loaded), 32'd3);

        // Empty image: DONE two edges after the first header byte.
        pulse_load_req();
        send_byte(8'h00);
        check_eq("t3_not_done", 32'(cpu_run), 32'd0);
        send_byte(8'h00);
        check_eq("t3_done", 32'(cpu_run), 32'd1);
        check_eq("t3_words", 32'(words_loaded), 32'd0);

        // Oversized header: error state swallows bytes.
        pulse_load_req();
        send_hdr(16'h0101);
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_run", 32'(cpu_run), 32'd0);
        check_eq("t4_ready", 32'(bus.s_ready), 32'd1);
        send_word(8'd0, 32'h5555_AAAA, 1'b0, 1'b0);
        check_eq("t4_err_hold", 32'(err), 32'd1);
        check_eq("t4_words", 32'(words_loaded), 32'd0);
        pulse_load_req();
        check_eq("t4_err_clr", 32'(err), 32'd0);
        send_hdr(16'h0001);
        send_word(8'd0, 32'hCAFE_F00D);
        wait_run();
        check_eq("t4_words_ok", 32'(words_loaded), 32'd1);

        // Back-to-back two-word reload.
        pulse_load_req();
        send_hdr(16'h0002);
        send_word(8'd0, 32'h1111_2222);
        send_word(8'd1, 32'h3333_4444);
        wait_run();
        check_eq("t5_words", 32'(words_loaded), 32'd2);

        // Reset mid-word: partial word dropped, loader waits for a fresh header.
        pulse_load_req();
        send_hdr(16'h0002);
        send_word(8'd0, 32'h7777_8888);
        send_byte(8'h99);
        send_byte(8'hAA);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_state();
        send_hdr(16'h0001);
        send_word(8'd0, 32'h0BAD_CAFE);
        wait_run();
        check_eq("t6_words", 32'(words_loaded), 32'd1);

        repeat (3) @(posedge clk);
        #1 check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
